// File: rtl/mio_bus_arbiter_if.sv
// Handshake and bus signals shared between the two masters, the arbiter and the MIO decoder.
interface mio_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_mem_w;
  logic [31:0] bus_rdata;

  logic        busy;
  logic        owner;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output bus_addr, bus_wdata, bus_mem_w,
    input  bus_rdata,
    output busy, owner
  );

  // Environment side: both masters plus the decoder.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  bus_addr, bus_wdata, bus_mem_w,
    output bus_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Two-master MIO bus arbiter: fixed priority to master 0, with a starvation counter that
// guarantees master 1 a slot after STARVE_LIMIT master-0 grants made while it waits.
module mio_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  mio_bus_arbiter_if.slave mio
);

  localparam int unsigned StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [3:0]         WaitInit  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e               state_q;
  logic [3:0]           wait_cnt_q;
  logic [StarveW-1:0]   starve_cnt_q;
  logic                 owner_q;
  logic                 busy_q;
  logic                 lat_we_q;
  logic [31:0]          bus_addr_q;
  logic [31:0]          bus_wdata_q;
  logic                 bus_mem_w_q;
  logic                 m0_ack_q;
  logic                 m1_ack_q;
  logic [31:0]          m0_rdata_q;
  logic [31:0]          m1_rdata_q;

  logic                 grant_m1;
  logic                 win_we;
  logic [31:0]          win_addr;
  logic [31:0]          win_wdata;

  // Pick the IDLE-cycle winner and mux its request fields.
  always_comb begin
    grant_m1  = mio.m1_req && (!mio.m0_req || (starve_cnt_q >= StarveMax));
    win_we    = grant_m1 ? mio.m1_we    : mio.m0_we;
    win_addr  = grant_m1 ? mio.m1_addr  : mio.m0_addr;
    win_wdata = grant_m1 ? mio.m1_wdata : mio.m0_wdata;
  end

  // Arbitration FSM with registered bus, ack and read-data outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      lat_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_mem_w_q  <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mio.m0_req || mio.m1_req) begin
            state_q     <= StAccess;
            busy_q      <= 1'b1;
            wait_cnt_q  <= WaitInit;
            owner_q     <= grant_m1;
            lat_we_q    <= win_we;
            bus_addr_q  <= win_addr;
            bus_wdata_q <= win_wdata;
            // Strobe lands in the last ACCESS cycle; with a one-cycle access that is the next one.
            bus_mem_w_q <= win_we && (WaitInit == 4'd1);
            if (grant_m1) begin
              starve_cnt_q <= '0;
            end else if (mio.m1_req && (starve_cnt_q < StarveMax)) begin
              starve_cnt_q <= starve_cnt_q + StarveW'(1);
            end
          end
        end
        StAccess: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            state_q     <= StDone;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_mem_w_q <= 1'b0;
            if (owner_q) begin
              m1_ack_q <= 1'b1;
              if (!lat_we_q) m1_rdata_q <= mio.bus_rdata;
            end else begin
              m0_ack_q <= 1'b1;
              if (!lat_we_q) m0_rdata_q <= mio.bus_rdata;
            end
          end else begin
            bus_mem_w_q <= lat_we_q && (wait_cnt_q == 4'd2);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mio.m0_ack    = m0_ack_q;
  assign mio.m1_ack    = m1_ack_q;
  assign mio.m0_rdata  = m0_rdata_q;
  assign mio.m1_rdata  = m1_rdata_q;
  assign mio.bus_addr  = bus_addr_q;
  assign mio.bus_wdata = bus_wdata_q;
  // Gate with reset so no strobe escapes in a cycle where reset is asserted.
  assign mio.bus_mem_w = bus_mem_w_q & rst;
  assign mio.busy      = busy_q;
  assign mio.owner     = owner_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: one instance with a 1-cycle access, one with 3 cycles.
module tb_mio_bus_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mio_bus_arbiter_if if1 ();
  mio_bus_arbiter_if if3 ();

  mio_bus_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .mio (if1)
  );

  mio_bus_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .mio (if3)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         got_n;
    int         cyc;
    int         lat;
    int         strobes;
    logic [9:0] order;
    logic       both_ack;

    rst           = 1'b0;
    if1.m0_req    = 1'b0; if1.m0_we = 1'b0; if1.m0_addr = '0; if1.m0_wdata = '0;
    if1.m1_req    = 1'b0; if1.m1_we = 1'b0; if1.m1_addr = '0; if1.m1_wdata = '0;
    if1.bus_rdata = '0;
    if3.m0_req    = 1'b0; if3.m0_we = 1'b0; if3.m0_addr = '0; if3.m0_wdata = '0;
    if3.m1_req    = 1'b0; if3.m1_we = 1'b0; if3.m1_addr = '0; if3.m1_wdata = '0;
    if3.bus_rdata = '0;

    // Reset state.
    tick(); tick();
    check("rst_m0_ack",   if1.m0_ack,    0);
    check("rst_m1_ack",   if1.m1_ack,    0);
    check("rst_busy",     if1.busy,      0);
    check("rst_owner",    if1.owner,     0);
    check("rst_bus_addr", if1.bus_addr,  0);
    check("rst_mem_w",    if3.bus_mem_w, 0);
    check("rst_m0_rdata", if1.m0_rdata,  0);
    rst = 1'b1;
    tick();

    // Single m0 read, 1-cycle access.
    if1.m0_req = 1'b1; if1.m0_we = 1'b0; if1.m0_addr = 32'h0000_0010;
    if1.bus_rdata = 32'hDEAD_BEEF;
    tick();
    check("rd_acc_addr",  if1.bus_addr,  32'h0000_0010);
    check("rd_acc_mem_w", if1.bus_mem_w, 0);
    check("rd_acc_busy",  if1.busy,      1);
    check("rd_acc_ack",   if1.m0_ack,    0);
    tick();
    check("rd_done_ack",   if1.m0_ack,   1);
    check("rd_done_rdata", if1.m0_rdata, 32'hDEAD_BEEF);
    check("rd_done_addr",  if1.bus_addr, 0);
    check("rd_done_busy",  if1.busy,     1);
    if1.m0_req = 1'b0;
    tick();
    check("rd_idle_ack",  if1.m0_ack, 0);
    check("rd_idle_busy", if1.busy,   0);

    // m1 write, 3-cycle access: single strobe in the third ACCESS cycle.
    if3.m1_req = 1'b1; if3.m1_we = 1'b1; if3.m1_addr = 32'hE000_0000;
    if3.m1_wdata = 32'h1234_5678; if3.bus_rdata = 32'hAAAA_5555;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("wr_mem_w_c%0d", i), if3.bus_mem_w, (i == 3) ? 1 : 0);
      check($sformatf("wr_addr_c%0d", i),  if3.bus_addr,  32'hE000_0000);
      check($sformatf("wr_ack_c%0d", i),   if3.m1_ack,    0);
    end
    check("wr_wdata", if3.bus_wdata, 32'h1234_5678);
    check("wr_owner", if3.owner,     1);
    tick();
    check("wr_done_ack",    if3.m1_ack,    1);
    check("wr_done_mem_w",  if3.bus_mem_w, 0);
    check("wr_done_rdata",  if3.m1_rdata,  0);
    check("wr_done_m0_ack", if3.m0_ack,    0);
    if3.m1_req = 1'b0;
    tick();

    // Both requesting continuously: m0 x4 then m1, twice.
    if1.m0_req = 1'b1; if1.m0_we = 1'b0; if1.m0_addr = 32'h0000_0100;
    if1.m1_req = 1'b1; if1.m1_we = 1'b0; if1.m1_addr = 32'h0000_0200;
    got_n = 0; cyc = 0; order = '0; both_ack = 1'b0;
    while (got_n < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (if1.m0_ack && if1.m1_ack) both_ack = 1'b1;
      if (if1.m0_ack || if1.m1_ack) begin
        order[got_n] = if1.m1_ack;
        got_n++;
      end
    end
    if1.m0_req = 1'b0; if1.m1_req = 1'b0;
    check("arb_grants", got_n,    10);
    check("arb_order",  order,    10'b10_0001_0000);
    check("arb_dual",   both_ack, 0);
    tick();

    // m0 alone for 10 accesses leaves the starvation count at 0; m0 then wins a tie.
    if1.m0_req = 1'b1; if1.m1_req = 1'b0;
    got_n = 0; cyc = 0;
    while (got_n < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (if1.m0_ack) got_n++;
    end
    if1.m0_req = 1'b0;
    check("solo_grants", got_n, 10);
    tick();
    check("solo_starve", u_dut1.starve_cnt_q, 0);
    if1.m0_req = 1'b1; if1.m1_req = 1'b1;
    tick();
    check("tie_owner",  if1.owner, 0);
    check("tie_starve", u_dut1.starve_cnt_q, 1);
    tick();
    check("tie_m0_ack", if1.m0_ack, 1);
    check("tie_m1_ack", if1.m1_ack, 0);
    if1.m0_req = 1'b0; if1.m1_req = 1'b0;
    tick();

    // Reset in the second ACCESS cycle of a write abandons it.
    if3.m0_req = 1'b1; if3.m0_we = 1'b1; if3.m0_addr = 32'h0000_0020;
    if3.m0_wdata = 32'h0000_0055;
    tick();
    check("ra_c1_mem_w", if3.bus_mem_w, 0);
    tick();
    rst = 1'b0;
    if3.m0_req = 1'b0;
    check("ra_c2_mem_w", if3.bus_mem_w, 0);
    tick();
    rst = 1'b1;
    check("ra_post_addr",  if3.bus_addr,  0);
    check("ra_post_wdata", if3.bus_wdata, 0);
    check("ra_post_mem_w", if3.bus_mem_w, 0);
    check("ra_post_ack",   if3.m0_ack,    0);
    check("ra_post_busy",  if3.busy,      0);
    check("ra_post_owner", if3.owner,     0);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if3.bus_mem_w || if3.m0_ack) strobes++;
    end
    check("ra_quiet", strobes, 0);

    // Next request after reset completes normally with ack on the 4th cycle.
    if3.m0_req = 1'b1; if3.m0_we = 1'b0; if3.m0_addr = 32'h0000_0030;
    if3.bus_rdata = 32'hCAFE_F00D;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!if3.m0_ack && lat < 10);
    check("ra_next_lat",   lat,          4);
    check("ra_next_rdata", if3.m0_rdata, 32'hCAFE_F00D);
    if3.m0_req = 1'b0;
    tick();

    // Request fields changing mid-access do not reach the bus.
    if3.m0_req = 1'b1; if3.m0_we = 1'b1; if3.m0_addr = 32'h0000_0040;
    if3.m0_wdata = 32'h1111_1111;
    tick();
    if3.m0_addr = 32'h0000_FFFF; if3.m0_wdata = 32'h2222_2222;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("hold_addr_c%0d", i),  if3.bus_addr,  32'h0000_0040);
      check($sformatf("hold_wdata_c%0d", i), if3.bus_wdata, 32'h1111_1111);
      if (i < 3) tick();
    end
    check("hold_mem_w", if3.bus_mem_w, 1);
    tick();
    check("hold_ack",       if3.m0_ack,   1);
    check("hold_done_addr", if3.bus_addr, 0);
    check("hold_rdata",     if3.m0_rdata, 32'hCAFE_F00D);
    if3.m0_req = 1'b0;
    tick();

    // Reset in the strobe cycle suppresses the strobe immediately.
    if3.m0_req = 1'b1; if3.m0_we = 1'b1; if3.m0_addr = 32'h0000_0050;
    if3.m0_wdata = 32'h0000_0077;
    tick(); tick(); tick();
    check("gate_pre_mem_w", if3.bus_mem_w, 1);
    rst = 1'b0;
    if3.m0_req = 1'b0;
    #1;
    check("gate_mem_w", if3.bus_mem_w, 0);
    tick();
    rst = 1'b1;
    check("gate_ack", if3.m0_ack, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
